interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port: irr  input  8  pending requests from the interrupt request register.
REQ-004 SHALL have port: imr  input  8  mask; 1 = level masked.
REQ-005 SHALL have port: INTA  input  1  active-low CPU acknowledge pin, asynchronous to clk.
REQ-006 SHALL have port: vector_base  input  5  T7..T3 of the vector (ICW2).
REQ-007 SHALL have port: aeoi  input  1  auto-EOI mode.
REQ-008 SHALL have ports: eoi_strobe, eoi_specific, eoi_rotate, set_prio_strobe  input  1 each; eoi_level  input  3.
REQ-009 SHALL have port: INT  output  1  interrupt request to the CPU.
REQ-010 SHALL have port: isr  output  8  in-service register.
REQ-011 SHALL have ports: clear_irr  output  1  one-cycle pulse; clear_index  output  3  IRR bit to clear.
REQ-012 SHALL have ports: data_out  output  8  vector byte; data_oe  output  1  vector drive enable.

Function
REQ-013 SHALL synchronize INTA through 2 flops; fall/rise = edge of the synchronized value, acted on in the same cycle as detection.
REQ-014 SHALL hold a 3-bit lowest-priority pointer L; priority order is L+1 (highest) .. L (lowest), modulo 8.
REQ-015 SHALL compute the winner as the highest-priority bit of (irr & ~imr), eligible only if strictly higher than the highest-priority set isr bit (fully nested).
REQ-016 SHALL implement FSM states IDLE, WAIT1, ACK1, WAIT2, ACK2.
REQ-017 IDLE: winner exists -> INT=1 next cycle, go WAIT1.
REQ-018 WAIT1: winner disappears before INTA fall -> INT=0, back to IDLE; INTA fall -> ACK1.
REQ-019 On ACK1 entry: latch idx=winner, set isr[idx], pulse clear_irr=1 with clear_index=idx for exactly one cycle, INT=0.
REQ-020 No winner at first INTA fall (spurious): idx=7, isr unchanged, clear_irr not pulsed.
REQ-021 ACK1 -> WAIT2 on INTA rise; WAIT2 -> ACK2 on INTA fall.
REQ-022 On ACK2 entry: data_out={vector_base, idx}, data_oe=1; held until INTA rise.
REQ-023 On INTA rise in ACK2: data_oe=0; if aeoi and not spurious, clear isr[idx]; then go IDLE.
REQ-024 eoi_strobe (1 cycle, any state): eoi_specific=1 clears isr[eoi_level]; else clears the highest-priority set isr bit; no bit set -> no effect.
REQ-025 eoi_strobe with eoi_rotate=1 SHALL also set L to the cleared level (no change if nothing cleared).
REQ-026 set_prio_strobe SHALL set L=eoi_level; if coincident with eoi_strobe, set_prio wins for L.
REQ-027 isr set (ACK1) and clear (EOI) in the same cycle SHALL both apply; if on the same bit, set wins.
REQ-028 data_out SHALL remain at its last value when data_oe=0.
REQ-029 Priority evaluation SHALL use current-cycle irr/imr/isr; winner is frozen only at ACK1.

Reset
REQ-030 reset=0 SHALL force: state IDLE, INT=0, isr=8'h00, clear_irr=0, clear_index=0, data_out=8'h00, data_oe=0, L=3'd7, synchronizer flops to 1 (INTA idle high).
REQ-031 Reset asserted mid-acknowledge SHALL abort the cycle with no further ISR/IRR side effects.
REQ-032 The first INTA edge is acted on no earlier than the 2nd clk edge after reset release.

Verification
REQ-033 irr=8'h0C, imr=0, L=7, vector_base=5'h08 -> INT=1; two INTA pulses -> clear_irr pulse, clear_index=2, isr=8'h04, data_out=8'h42.
REQ-034 isr=8'h04, irr=8'h08 -> INT stays 0; irr=8'h01 -> INT=1 (nesting).
REQ-035 aeoi=1, irr=8'h80 -> after 2nd INTA rise isr=8'h00, data_out low bits=7.
REQ-036 isr=8'h14, non-specific eoi_strobe with eoi_rotate=1 -> isr=8'h10, L=2; then irr=8'h09 -> winner IR3.
REQ-037 irr drops to 0 between INT and 1st INTA -> spurious: isr unchanged, no clear_irr, vector low bits=7.
REQ-038 reset=0 asserted during ACK2 -> data_oe=0, INT=0, isr=8'h00, L=7 immediately, no clk edge required.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: rotating-priority resolver with fully nested in-service
// tracking, a two-pulse INTA acknowledge handshake that delivers the vector
// byte, and EOI / priority-set command handling.
module interrupt_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       INTA,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       eoi_strobe,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic       set_prio_strobe,
    input  logic [2:0] eoi_level,
    output logic       INT,
    output logic [7:0] isr,
    output logic       clear_irr,
    output logic [2:0] clear_index,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {IDLE, WAIT1, ACK1, WAIT2, ACK2} state_t;

    state_t     state_q;
    logic       int_q, clear_irr_q, data_oe_q, spur_q;
    logic [7:0] isr_q, isr_d, data_out_q;
    logic [2:0] clear_index_q, idx_q, lp_q, lp_d;
    logic       inta_s1_q, inta_s2_q, inta_prev_q;
    logic       inta_fall, inta_rise;

    logic [7:0] req, eoi_clr, isr_set, isr_aeoi_clr;
    logic [2:0] win_idx, isr_top, eoi_lvl;
    logic       win_valid, eoi_hit;

    // Highest-priority set bit of v when l is the lowest-priority level.
    // Scanning from the lowest priority upward lets the highest one win last.
    function automatic logic [2:0] first_idx(input logic [7:0] v, input logic [2:0] l);
        logic [2:0] pos;
        first_idx = l;
        for (int k = 7; k >= 0; k--) begin
            pos = l + 3'd1 + 3'(k);
            if (v[pos]) first_idx = pos;
        end
    endfunction

    // Rank 0 is the highest priority (level l+1), rank 7 the lowest (level l).
    function automatic logic [2:0] prio_rank(input logic [2:0] i, input logic [2:0] l);
        prio_rank = i - l - 3'd1;
    endfunction

    assign inta_fall = inta_prev_q & ~inta_s2_q;
    assign inta_rise = ~inta_prev_q & inta_s2_q;

    // Bring INTA into the clk domain and keep one more stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inta_s1_q   <= 1'b1;
            inta_s2_q   <= 1'b1;
            inta_prev_q <= 1'b1;
        end else begin
            inta_s1_q   <= INTA;
            inta_s2_q   <= inta_s1_q;
            inta_prev_q <= inta_s2_q;
        end
    end

    // Resolve the winning request; it must outrank everything in service.
    always_comb begin
        req       = irr & ~imr;
        win_idx   = first_idx(req, lp_q);
        isr_top   = first_idx(isr_q, lp_q);
        win_valid = (|req) &&
                    (!(|isr_q) || (prio_rank(win_idx, lp_q) < prio_rank(isr_top, lp_q)));
    end

    // Decode the EOI command into the single in-service bit it retires.
    always_comb begin
        eoi_clr = 8'h00;
        eoi_hit = 1'b0;
        eoi_lvl = eoi_level;
        if (eoi_strobe) begin
            if (eoi_specific) begin
                eoi_hit = isr_q[eoi_level];
            end else begin
                eoi_hit = |isr_q;
                eoi_lvl = isr_top;
            end
        end
        if (eoi_hit) eoi_clr[eoi_lvl] = 1'b1;
    end

    // Next ISR and priority pointer; a set on the same bit as a clear wins.
    always_comb begin
        isr_set      = 8'h00;
        isr_aeoi_clr = 8'h00;
        if (state_q == WAIT1 && inta_fall && win_valid) isr_set[win_idx] = 1'b1;
        if (state_q == ACK2 && inta_rise && aeoi && !spur_q) isr_aeoi_clr[idx_q] = 1'b1;
        isr_d = (isr_q & ~eoi_clr & ~isr_aeoi_clr) | isr_set;

        lp_d = lp_q;
        if (eoi_strobe && eoi_rotate && eoi_hit) lp_d = eoi_lvl;
        if (set_prio_strobe) lp_d = eoi_level;
    end

    // Acknowledge sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            int_q         <= 1'b0;
            isr_q         <= 8'h00;
            lp_q          <= 3'd7;
            clear_irr_q   <= 1'b0;
            clear_index_q <= 3'd0;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            idx_q         <= 3'd7;
            spur_q        <= 1'b0;
        end else begin
            isr_q       <= isr_d;
            lp_q        <= lp_d;
            clear_irr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        int_q   <= 1'b1;
                        state_q <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (inta_fall) begin
                        int_q   <= 1'b0;
                        state_q <= ACK1;
                        if (win_valid) begin
                            idx_q         <= win_idx;
                            spur_q        <= 1'b0;
                            clear_irr_q   <= 1'b1;
                            clear_index_q <= win_idx;
                        end else begin
                            idx_q  <= 3'd7;
                            spur_q <= 1'b1;
                        end
                    end else if (!win_valid) begin
                        int_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACK1: begin
                    if (inta_rise) state_q <= WAIT2;
                end
                WAIT2: begin
                    if (inta_fall) begin
                        data_out_q <= {vector_base, idx_q};
                        data_oe_q  <= 1'b1;
                        state_q    <= ACK2;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        data_oe_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign INT         = int_q;
    assign isr         = isr_q;
    assign clear_irr   = clear_irr_q;
    assign clear_index = clear_index_q;
    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: acknowledge handshake, nesting,
// EOI and rotation, auto-EOI, spurious acknowledge and asynchronous reset.
module tb_interrupt_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] irr, imr;
    logic       INTA;
    logic [4:0] vector_base;
    logic       aeoi, eoi_strobe, eoi_specific, eoi_rotate, set_prio_strobe;
    logic [2:0] eoi_level;
    logic       INT;
    logic [7:0] isr;
    logic       clear_irr;
    logic [2:0] clear_index;
    logic [7:0] data_out;
    logic       data_oe;

    int         n_checks = 0;
    int         n_errors = 0;
    int         clr_total = 0;
    int         base;
    logic [2:0] clr_last = 3'd0;

    interrupt_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .irr             (irr),
        .imr             (imr),
        .INTA            (INTA),
        .vector_base     (vector_base),
        .aeoi            (aeoi),
        .eoi_strobe      (eoi_strobe),
        .eoi_specific    (eoi_specific),
        .eoi_rotate      (eoi_rotate),
        .set_prio_strobe (set_prio_strobe),
        .eoi_level       (eoi_level),
        .INT             (INT),
        .isr             (isr),
        .clear_irr       (clear_irr),
        .clear_index     (clear_index),
        .data_out        (data_out),
        .data_oe         (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count clear_irr high cycles and remember the last index it carried.
    always @(posedge clk) begin
        if (clear_irr) begin
            clr_total <= clr_total + 1;
            clr_last  <= clear_index;
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inta_fall();
        INTA = 1'b0;
        tick(4);
    endtask

    task automatic inta_rise();
        INTA = 1'b1;
        tick(4);
    endtask

    task automatic full_ack(input logic [7:0] irr_after);
        inta_fall();
        irr = irr_after;
        inta_rise();
        inta_fall();
        inta_rise();
    endtask

    task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
        eoi_strobe   = 1'b1;
        eoi_specific = spec;
        eoi_rotate   = rot;
        eoi_level    = lvl;
        tick(1);
        eoi_strobe   = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
    endtask

    task automatic set_prio(input logic [2:0] lvl);
        set_prio_strobe = 1'b1;
        eoi_level       = lvl;
        tick(1);
        set_prio_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b0; irr = 8'h00; imr = 8'h00; INTA = 1'b1;
        vector_base = 5'h08; aeoi = 1'b0; eoi_strobe = 1'b0; eoi_specific = 1'b0;
        eoi_rotate = 1'b0; set_prio_strobe = 1'b0; eoi_level = 3'd0;
        tick(2);
        check_eq("rst_int", 8'(INT), 8'h00);
        check_eq("rst_isr", isr, 8'h00);
        check_eq("rst_clr", 8'(clear_irr), 8'h00);
        check_eq("rst_cidx", 8'(clear_index), 8'h00);
        check_eq("rst_dout", data_out, 8'h00);
        check_eq("rst_doe", 8'(data_oe), 8'h00);
        reset = 1'b1;
        tick(2);

        // Basic acknowledge: IR2 beats IR3 with L=7
        irr = 8'h0C;
        tick(2);
        check_eq("ack_int", 8'(INT), 8'h01);
        base = clr_total;
        inta_fall();
        check_eq("ack1_int", 8'(INT), 8'h00);
        check_eq("ack1_clrcnt", 8'(clr_total - base), 8'h01);
        check_eq("ack1_cidx", 8'(clr_last), 8'h02);
        check_eq("ack1_isr", isr, 8'h04);
        irr = 8'h08;
        inta_rise();
        inta_fall();
        check_eq("ack2_doe", 8'(data_oe), 8'h01);
        check_eq("ack2_dout", data_out, 8'h42);
        inta_rise();
        check_eq("end_doe", 8'(data_oe), 8'h00);
        check_eq("end_dout_hold", data_out, 8'h42);
        check_eq("end_isr", isr, 8'h04);

        // Nesting: IR3 blocked by IR2 in service, IR0 allowed
        tick(3);
        check_eq("nest_blocked", 8'(INT), 8'h00);
        irr = 8'h01;
        tick(2);
        check_eq("nest_int", 8'(INT), 8'h01);
        full_ack(8'h00);
        check_eq("nest_isr", isr, 8'h05);
        check_eq("nest_cidx", 8'(clr_last), 8'h00);
        check_eq("nest_dout", data_out, 8'h40);

        // EOI: non-specific clears IR0, specific clears IR2
        eoi(1'b0, 1'b0, 3'd0);
        check_eq("eoi_ns_isr", isr, 8'h04);
        eoi(1'b1, 1'b0, 3'd2);
        check_eq("eoi_sp_isr", isr, 8'h00);

        // Rotation: build isr=14, rotate-EOI, then IR3 beats IR0
        irr = 8'h10;
        tick(2);
        full_ack(8'h00);
        irr = 8'h04;
        tick(2);
        check_eq("rot_int", 8'(INT), 8'h01);
        full_ack(8'h00);
        check_eq("rot_isr14", isr, 8'h14);
        eoi(1'b0, 1'b1, 3'd0);
        check_eq("rot_isr10", isr, 8'h10);
        irr = 8'h09;
        tick(2);
        check_eq("rot_int2", 8'(INT), 8'h01);
        full_ack(8'h00);
        check_eq("rot_cidx", 8'(clr_last), 8'h03);
        check_eq("rot_isr18", isr, 8'h18);
        check_eq("rot_dout", data_out, 8'h43);
        eoi(1'b1, 1'b0, 3'd3);
        eoi(1'b1, 1'b0, 3'd4);
        check_eq("rot_clean", isr, 8'h00);
        set_prio(3'd7);

        // Auto-EOI on IR7
        aeoi = 1'b1;
        irr = 8'h80;
        tick(2);
        inta_fall();
        check_eq("aeoi_isr_set", isr, 8'h80);
        irr = 8'h00;
        inta_rise();
        inta_fall();
        inta_rise();
        check_eq("aeoi_isr_clr", isr, 8'h00);
        check_eq("aeoi_dout", data_out, 8'h47);
        aeoi = 1'b0;

        // Put IR5 in service, then withdraw a request while INT is up
        irr = 8'h20;
        tick(2);
        full_ack(8'h00);
        check_eq("ir5_isr", isr, 8'h20);
        irr = 8'h02;
        tick(2);
        check_eq("w1_int", 8'(INT), 8'h01);
        irr = 8'h00;
        tick(2);
        check_eq("w1_drop", 8'(INT), 8'h00);

        // Spurious: request vanishes exactly when the first INTA fall lands
        irr = 8'h02;
        tick(2);
        check_eq("sp_int", 8'(INT), 8'h01);
        vector_base = 5'h11;
        base = clr_total;
        INTA = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        irr = 8'h00;
        tick(3);
        check_eq("sp_int0", 8'(INT), 8'h00);
        check_eq("sp_noclr", 8'(clr_total - base), 8'h00);
        check_eq("sp_isr", isr, 8'h20);
        inta_rise();
        inta_fall();
        check_eq("sp_doe", 8'(data_oe), 8'h01);
        check_eq("sp_dout", data_out, 8'h8F);
        inta_rise();
        check_eq("sp_isr_end", isr, 8'h20);
        eoi(1'b1, 1'b0, 3'd5);
        check_eq("sp_clean", isr, 8'h00);

        // Asynchronous reset during ACK2 with L moved to 1
        vector_base = 5'h08;
        set_prio(3'd1);
        irr = 8'h04;
        tick(2);
        inta_fall();
        irr = 8'h00;
        inta_rise();
        inta_fall();
        check_eq("ar_doe_pre", 8'(data_oe), 8'h01);
        check_eq("ar_isr_pre", isr, 8'h04);
        #1;
        reset = 1'b0;
        INTA  = 1'b1;
        #1;
        check_eq("ar_doe", 8'(data_oe), 8'h00);
        check_eq("ar_int", 8'(INT), 8'h00);
        check_eq("ar_isr", isr, 8'h00);
        check_eq("ar_dout", data_out, 8'h00);
        tick(2);
        reset = 1'b1;
        irr = 8'h06;
        tick(2);
        check_eq("ar_int2", 8'(INT), 8'h01);
        base = clr_total;
        full_ack(8'h00);
        check_eq("ar_clrcnt", 8'(clr_total - base), 8'h01);
        check_eq("ar_L7_cidx", 8'(clr_last), 8'h01);
        check_eq("ar_dout2", data_out, 8'h41);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
